// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and default counter width.
package pwm_capture_pkg;

   localparam int CNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } state_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// Synchronizes pwm_in, optionally filters it (PWM_CAPTURE_FILTER_EN), and emits
// one-cycle rise/fall events together with the level they refer to.
module pwm_edge_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic pwm_in,
   output logic rise,
   output logic fall,
   output logic level
);

   logic sync_0;
   logic sync_1;
   logic src;
   logic src_d;

`ifdef PWM_CAPTURE_FILTER_EN
   logic tap_a;
   logic filt;

   // Majority of the two newest samples and the filter's own output: the output
   // only moves once two consecutive samples agree, so 1-clock pulses never pass.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tap_a <= 1'b0;
         filt  <= 1'b0;
      end else begin
         tap_a <= sync_1;
         filt  <= (sync_1 & tap_a) | (sync_1 & filt) | (tap_a & filt);
      end
   end

   assign src = filt;
`else
   assign src = sync_1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
         src_d  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_0 <= pwm_in;
         sync_1 <= sync_0;
         src_d  <= src;
         rise   <= src & ~src_d;
         fall   <= ~src & src_d;
      end
   end

   // src_d is the level that produced the current rise/fall event.
   assign level = src_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period measurement with saturating counter and stuck-level timeout.
// Optional 1-clock glitch filter selected by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             capture_en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_count,
   output logic [CNT_W-1:0] period_count,
   output logic             capture_valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic rise;
   logic fall;
   logic level;

   state_t           state,    state_nx;
   logic [CNT_W-1:0] counter,  counter_nx;
   logic [CNT_W-1:0] hi_tmp,   hi_tmp_nx;
   logic [CNT_W-1:0] high_nx,  period_nx;
   logic             valid_nx, timeout_nx, stuck_nx;
   logic             at_max;
   logic [CNT_W-1:0] counter_sat;

   pwm_edge_detect u_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .pwm_in  (pwm_in),
      .rise    (rise),
      .fall    (fall),
      .level   (level)
   );

   assign at_max      = (counter == CNT_MAX);
   assign counter_sat = at_max ? CNT_MAX : counter + CNT_ONE;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      counter_nx = counter;
      hi_tmp_nx  = hi_tmp;
      high_nx    = high_count;
      period_nx  = period_count;
      valid_nx   = 1'b0;
      timeout_nx = 1'b0;
      stuck_nx   = stuck_level;

      if (!capture_en) begin
         state_nx   = IDLE;
         counter_nx = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nx   = WAIT_RISE;
               counter_nx = '0;
            end
            WAIT_RISE: begin
               if (rise) begin
                  state_nx   = HIGH;
                  counter_nx = CNT_ONE;
               end else if (at_max) begin
                  timeout_nx = 1'b1;
                  stuck_nx   = level;
                  counter_nx = '0;
               end else begin
                  counter_nx = counter_sat;
               end
            end
            HIGH: begin
               if (fall) begin
                  hi_tmp_nx  = counter;
                  counter_nx = counter_sat;
                  state_nx   = LOW;
               end else if (at_max) begin
                  timeout_nx = 1'b1;
                  stuck_nx   = level;
                  counter_nx = '0;
                  state_nx   = WAIT_RISE;
               end else begin
                  counter_nx = counter_sat;
               end
            end
            LOW: begin
               // Edges take priority over a coincident timeout.
               if (rise) begin
                  high_nx    = hi_tmp;
                  period_nx  = counter;
                  valid_nx   = 1'b1;
                  counter_nx = CNT_ONE;
                  state_nx   = HIGH;
               end else if (at_max) begin
                  timeout_nx = 1'b1;
                  stuck_nx   = level;
                  counter_nx = '0;
                  state_nx   = WAIT_RISE;
               end else begin
                  counter_nx = counter_sat;
               end
            end
            default: begin
               state_nx   = IDLE;
               counter_nx = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         counter       <= '0;
         hi_tmp        <= '0;
         high_count    <= '0;
         period_count  <= '0;
         capture_valid <= 1'b0;
         timeout       <= 1'b0;
         stuck_level   <= 1'b0;
      end else begin
         state         <= state_nx;
         counter       <= counter_nx;
         hi_tmp        <= hi_tmp_nx;
         high_count    <= high_nx;
         period_count  <= period_nx;
         capture_valid <= valid_nx;
         timeout       <= timeout_nx;
         stuck_level   <= stuck_nx;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: scoreboard of expected captures plus timeout checks on an 8-bit instance.
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] per;
   } cap_t;

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT  = 5;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit FILT = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        capture_en;
   logic        pwm_in;
   logic        pwm8;
   logic [15:0] high_count, period_count;
   logic        capture_valid, timeout, stuck_level;
   logic [7:0]  high8, period8;
   logic        valid8, timeout8, stuck8;
   logic        v8_seen = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   cap_t exp_q[$];
   cap_t exp_now;
   int   first_to, second_to;

   always #5 clock = ~clock;

   pwm_capture #(.CNT_W(16)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .capture_en    (capture_en),
      .pwm_in        (pwm_in),
      .high_count    (high_count),
      .period_count  (period_count),
      .capture_valid (capture_valid),
      .timeout       (timeout),
      .stuck_level   (stuck_level)
   );

   pwm_capture #(.CNT_W(8)) dut8 (
      .clock         (clock),
      .reset_n       (reset_n),
      .capture_en    (capture_en),
      .pwm_in        (pwm8),
      .high_count    (high8),
      .period_count  (period8),
      .capture_valid (valid8),
      .timeout       (timeout8),
      .stuck_level   (stuck8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_train(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = 1'b1;
         tick(hi);
         pwm_in = 1'b0;
         tick(lo);
      end
   endtask

   task automatic expect_cap(input int hi, input int per, input int n);
      cap_t c;
      c.hi  = 16'(hi);
      c.per = 16'(per);
      for (int i = 0; i < n; i++) exp_q.push_back(c);
   endtask

   task automatic restart();
      capture_en = 1'b0;
      tick(2);
      capture_en = 1'b1;
      tick(8);
   endtask

   // Scoreboard: every capture_valid must match the oldest pending expectation.
   always @(negedge clock) begin
      if (valid8) v8_seen = 1'b1;
      if (reset_n && capture_valid) begin
         check("capture_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_now = exp_q.pop_front();
            check("capture_high", 32'(high_count), 32'(exp_now.hi));
            check("capture_period", 32'(period_count), 32'(exp_now.per));
         end
      end
      if (reset_n && timeout) check("spurious_timeout", 32'(timeout), 0);
   end

   initial begin
      reset_n    = 1'b0;
      capture_en = 1'b0;
      pwm_in     = 1'b0;
      pwm8       = 1'b0;
      tick(3);
      check("rst_high", 32'(high_count), 0);
      check("rst_period", 32'(period_count), 0);
      check("rst_valid", 32'(capture_valid), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_stuck", 32'(stuck_level), 0);
      reset_n = 1'b1;

      // 64 high / 192 low: captures from the second rise onward
      capture_en = 1'b1;
      tick(8);
      expect_cap(64, 256, 3);
      pulse_train(64, 192, 4);
      tick(10);
      check("basic_drain", 32'(exp_q.size()), 0);
      check("basic_high", 32'(high_count), 64);
      check("basic_period", 32'(period_count), 256);

      // 1 high / 1 low: measured without the filter, rejected with it
      restart();
      if (!FILT) expect_cap(1, 2, 5);
      pulse_train(1, 1, 6);
      tick(10);
      check("minpulse_drain", 32'(exp_q.size()), 0);
      check("minpulse_high", 32'(high_count), FILT ? 64 : 1);
      check("minpulse_period", 32'(period_count), FILT ? 256 : 2);

      // Disable during LOW of the 2nd period, then re-enable for a fresh capture
      restart();
      expect_cap(10, 40, 1);
      pulse_train(10, 30, 1);
      pwm_in = 1'b1;
      tick(10);
      pwm_in = 1'b0;
      tick(5);
      capture_en = 1'b0;
      tick(25);
      pulse_train(10, 30, 1);
      check("disable_drain", 32'(exp_q.size()), 0);
      check("disable_hold_high", 32'(high_count), 10);
      check("disable_hold_period", 32'(period_count), 40);
      capture_en = 1'b1;
      tick(10);
      expect_cap(20, 70, 2);
      pulse_train(20, 50, 3);
      tick(10);
      check("reenable_drain", 32'(exp_q.size()), 0);

      // 1-clock glitch inside a 100-clock low phase
      restart();
      if (FILT) expect_cap(30, 130, 3);
      else begin
         expect_cap(30, 130, 1);
         expect_cap(30, 79, 1);
         expect_cap(1, 51, 1);
         expect_cap(30, 130, 1);
      end
      pulse_train(30, 100, 1);
      pwm_in = 1'b1;
      tick(30);
      pwm_in = 1'b0;
      tick(49);
      pwm_in = 1'b1;
      tick(1);
      pwm_in = 1'b0;
      tick(50);
      pulse_train(30, 100, 1);
      pwm_in = 1'b1;
      tick(30);
      pwm_in = 1'b0;
      tick(10);
      check("glitch_drain", 32'(exp_q.size()), 0);
      check("glitch_high", 32'(high_count), 30);
      check("glitch_period", 32'(period_count), 130);

      // Rise event and capture_en falling in the same cycle: no capture
      restart();
      pulse_train(10, 30, 1);
      pwm_in = 1'b1;
      tick(LAT);
      capture_en = 1'b0;
      tick(10);
      pwm_in = 1'b0;
      tick(10);
      check("race_drain", 32'(exp_q.size()), 0);
      check("race_hold_high", 32'(high_count), 30);
      check("race_hold_period", 32'(period_count), 130);

      // One-cycle reset mid-HIGH clears everything; next capture needs rise-fall-rise
      capture_en = 1'b1;
      tick(8);
      pwm_in = 1'b1;
      tick(10);
      reset_n = 1'b0;
      tick(1);
      check("midrst_high", 32'(high_count), 0);
      check("midrst_period", 32'(period_count), 0);
      check("midrst_valid", 32'(capture_valid), 0);
      check("midrst_timeout", 32'(timeout), 0);
      check("midrst_stuck", 32'(stuck_level), 0);
      check("midrst_state", 32'(dut.state), 32'(IDLE));
      reset_n = 1'b1;
      pwm_in  = 1'b0;
      tick(10);
      expect_cap(25, 100, 1);
      pulse_train(25, 75, 2);
      tick(10);
      check("postrst_drain", 32'(exp_q.size()), 0);
      check("postrst_high", 32'(high_count), 25);
      check("postrst_period", 32'(period_count), 100);

      // CNT_W=8, input held low: timeout every 256 clocks, stuck_level=0
      capture_en = 1'b0;
      tick(2);
      capture_en = 1'b1;
      first_to   = 0;
      second_to  = 0;
      for (int k = 1; k <= 600; k++) begin
         tick(1);
         if (timeout8) begin
            if (first_to == 0) first_to = k;
            else if (second_to == 0) second_to = k;
         end
      end
      check("to0_first", 32'(first_to), 257);
      check("to0_second", 32'(second_to), 513);
      check("to0_stuck", 32'(stuck8), 0);

      // Rise coinciding with the WAIT_RISE timeout wins; then held high times out in HIGH
      capture_en = 1'b0;
      tick(2);
      capture_en = 1'b1;
      first_to   = 0;
      for (int k = 1; k <= 600; k++) begin
         tick(1);
         if (timeout8 && first_to == 0) first_to = k;
         if (k == 256 - LAT) pwm8 = 1'b1;
      end
      check("to1_first", 32'(first_to), 512);
      check("to1_stuck", 32'(stuck8), 1);
      check("dut8_no_capture", 32'(v8_seen), 0);
      check("dut8_high", 32'(high8), 0);
      check("dut8_period", 32'(period8), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
